// File: rtl/pwr_switch_ack_model_if.sv
// Switch request / acknowledge bundle for the power-switch ack model.
interface pwr_switch_ack_model_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0] switch_i;
  logic [NCH-1:0] ack_o;
  logic           busy_o;
  logic [15:0]    abort_cnt_o;

  modport master (output switch_i, input ack_o, input busy_o, input abort_cnt_o);
  modport slave  (input switch_i, output ack_o, output busy_o, output abort_cnt_o);
endinterface

// File: rtl/pwr_switch_ack_model.sv
// Behavioural power-switch model: per-domain ack with independent on/off
// latencies, optional in-rush limit on concurrent ramp-ups, and a saturating
// count of aborted ramps.
module pwr_switch_ack_model #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned ON_LATENCY  = 15,
  parameter int unsigned OFF_LATENCY = 15,
  parameter int unsigned MAX_ACTIVE  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pwr_switch_ack_model_if.slave   bus
);
  localparam int unsigned MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit LIMITED = (MAX_ACTIVE != 0) && (MAX_ACTIVE < NCH);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT_UP,
    ST_RAMP_UP,
    ST_ON,
    ST_RAMP_DOWN
  } state_e;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [15:0]      abort_cnt_q, abort_cnt_d;
  logic [NCH-1:0]   grant;

  // Fixed-priority grant: lowest-index requesters take the free ramp slots,
  // computed from registered state so a slot frees one cycle after ramp end.
  always_comb begin
    int unsigned ramping;
    int unsigned given;
    ramping = 0;
    given   = 0;
    grant   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (state_q[i] == ST_RAMP_UP) ramping++;
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if ((state_q[i] == ST_OFF || state_q[i] == ST_WAIT_UP) && bus.switch_i[i]) begin
        if (!LIMITED || (given + ramping < MAX_ACTIVE)) begin
          grant[i] = 1'b1;
          given++;
        end
      end
    end
  end

  // Per-channel next state/counter and the saturating abort accumulator.
  always_comb begin
    int unsigned aborts;
    logic [16:0] abort_sum;
    aborts = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (bus.switch_i[i]) begin
            if (grant[i]) begin
              state_d[i] = ST_RAMP_UP;
              cnt_d[i]   = ON_LOAD;
            end else begin
              state_d[i] = ST_WAIT_UP;
            end
          end
        end
        ST_WAIT_UP: begin
          if (!bus.switch_i[i]) begin
            state_d[i] = ST_OFF;
          end else if (grant[i]) begin
            state_d[i] = ST_RAMP_UP;
            cnt_d[i]   = ON_LOAD;
          end
        end
        ST_RAMP_UP: begin
          if (!bus.switch_i[i]) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
            aborts++;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_ON;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        ST_ON: begin
          if (!bus.switch_i[i]) begin
            state_d[i] = ST_RAMP_DOWN;
            cnt_d[i]   = OFF_LOAD;
          end
        end
        ST_RAMP_DOWN: begin
          // Returning straight to ON keeps ack high without a glitch.
          if (bus.switch_i[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
            aborts++;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
    abort_sum   = {1'b0, abort_cnt_q} + 17'(aborts);
    abort_cnt_d = abort_sum[16] ? '1 : abort_sum[15:0];
  end

  // State, counter and abort-count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      abort_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      abort_cnt_q <= abort_cnt_d;
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    bus.ack_o  = '0;
    bus.busy_o = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.ack_o[i] = (state_q[i] == ST_ON) || (state_q[i] == ST_RAMP_DOWN);
      if (state_q[i] == ST_WAIT_UP || state_q[i] == ST_RAMP_UP ||
          state_q[i] == ST_RAMP_DOWN) begin
        bus.busy_o = 1'b1;
      end
    end
    bus.abort_cnt_o = abort_cnt_q;
  end
endmodule
